// File: rtl/ow_pkg.sv
// Shared 1-Wire definitions: slave state encoding and default bus timing in microseconds.
package ow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOW_CNT   = 3'd1,
        ST_PRES_WAIT = 3'd2,
        ST_PRESENCE  = 3'd3,
        ST_SLOT_WAIT = 3'd4,
        ST_SLOT      = 3'd5,
        ST_SLOT_END  = 3'd6
    } ow_state_e;

    localparam int OW_CLKS_PER_US  = 12;
    localparam int OW_RESET_MIN_US = 480;
    localparam int OW_PRES_WAIT_US = 30;
    localparam int OW_PRES_LEN_US  = 120;
    localparam int OW_SAMPLE_US    = 30;

    // Wide enough for the longest duration (bus reset) with margin.
    localparam int OW_TIMER_W      = 16;

endpackage

// File: rtl/ow_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, phase restarted on request.
module ow_us_tick
    import ow_pkg::*;
#(
    parameter int CLKS_PER_US = OW_CLKS_PER_US
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= CW'(CLKS_PER_US - 1);
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ow_slave.sv
// 1-Wire slave: reset/presence handling plus LSB-first byte receive and transmit.
// state      | meaning
// IDLE       | bus idle, no presence issued yet
// LOW_CNT    | line low, timing it to tell a bus reset from a stray pulse
// PRES_WAIT  | bus reset released, waiting before the presence pulse
// PRESENCE   | pulling the line low as the presence pulse
// SLOT_WAIT  | waiting for the master to open a time slot
// SLOT       | inside a slot, until the sample point
// SLOT_END   | sample taken, waiting for the line to return high
module ow_slave
    import ow_pkg::*;
#(
    parameter int CLKS_PER_US  = OW_CLKS_PER_US,
    parameter int RESET_MIN_US = OW_RESET_MIN_US,
    parameter int PRES_WAIT_US = OW_PRES_WAIT_US,
    parameter int PRES_LEN_US  = OW_PRES_LEN_US,
    parameter int SAMPLE_US    = OW_SAMPLE_US
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I_ONE_WIRE,
    output logic       O_ONE_WIRE,
    output logic       reset_seen,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_done
);

    ow_state_e              r_state, w_state_nxt;
    logic                   r_sync1, r_sync2, r_line_d;
    logic                   w_fall, w_rise, w_tick, w_long, w_expire, w_sample;
    logic [OW_TIMER_W-1:0]  r_timer, r_low_cnt, w_timer_load;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx_shift, r_tx_shift, r_rx_data;
    logic                   r_tx_pending, r_reset_seen, r_rx_valid, r_tx_done;

    // Synchroniser idles high so a reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= I_ONE_WIRE;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_fall = r_line_d & ~r_sync2;
    assign w_rise = ~r_line_d & r_sync2;

    ow_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_fall | w_rise),
        .o_tick    (w_tick)
    );

    // Low-time counter runs in every state, including while we drive the line ourselves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= '0;
        end else if (w_fall) begin
            r_low_cnt <= OW_TIMER_W'(RESET_MIN_US - 1);
        end else if (w_tick && !r_sync2 && r_low_cnt != '0) begin
            r_low_cnt <= r_low_cnt - OW_TIMER_W'(1);
        end
    end

    assign w_long   = (r_low_cnt == '0) && !r_line_d;
    assign w_expire = w_tick && (r_timer == '0);
    assign w_sample = (r_state == ST_SLOT) && w_expire;

    always_comb begin
        case (w_state_nxt)
            ST_PRES_WAIT: w_timer_load = OW_TIMER_W'(PRES_WAIT_US - 1);
            ST_PRESENCE:  w_timer_load = OW_TIMER_W'(PRES_LEN_US - 1);
            ST_SLOT:      w_timer_load = OW_TIMER_W'(SAMPLE_US - 1);
            default:      w_timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= w_timer_load;
        end else if (w_tick && r_timer != '0) begin
            r_timer <= r_timer - OW_TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_long && r_state != ST_LOW_CNT) begin
            w_state_nxt = ST_LOW_CNT;
        end else begin
            case (r_state)
                ST_IDLE:      if (w_fall)   w_state_nxt = ST_LOW_CNT;
                ST_LOW_CNT:   if (w_rise)   w_state_nxt = w_long ? ST_PRES_WAIT : ST_IDLE;
                ST_PRES_WAIT: if (w_expire) w_state_nxt = ST_PRESENCE;
                ST_PRESENCE:  if (w_expire) w_state_nxt = ST_SLOT_WAIT;
                ST_SLOT_WAIT: if (w_fall)   w_state_nxt = ST_SLOT;
                ST_SLOT:      if (w_expire) w_state_nxt = ST_SLOT_END;
                ST_SLOT_END:  if (r_sync2)  w_state_nxt = ST_SLOT_WAIT;
                default:                    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        O_ONE_WIRE = 1'b1;
        case (r_state)
            ST_PRESENCE: O_ONE_WIRE = 1'b0;
            ST_SLOT:     O_ONE_WIRE = !(r_tx_pending && !r_tx_shift[0]);
            default:     O_ONE_WIRE = 1'b1;
        endcase
    end

    // Bit counter is shared by both directions; a pending tx byte turns the slot into a read slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_rx_data    <= '0;
            r_tx_pending <= 1'b0;
            r_reset_seen <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_reset_seen <= (r_state == ST_LOW_CNT) && (w_state_nxt == ST_PRES_WAIT);
            r_rx_valid   <= 1'b0;
            r_tx_done    <= 1'b0;
            if (w_long) begin
                r_bit_cnt    <= '0;
                r_tx_pending <= 1'b0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_tx_pending) begin
                    r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        r_tx_pending <= 1'b0;
                        r_tx_done    <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_data  <= {r_sync2, r_rx_shift[7:1]};
                        r_rx_valid <= 1'b1;
                    end
                end
            end else if (tx_load && r_state == ST_SLOT_WAIT && !r_tx_pending) begin
                r_tx_shift   <= tx_data;
                r_tx_pending <= 1'b1;
            end
        end
    end

    assign reset_seen = r_reset_seen;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_ready   = !r_tx_pending;
    assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_ow_slave.sv
// Directed bench for ow_slave at 1 clk per us, with a wired-AND bus and a cycle-indexed expectation model.
module tb_ow_slave;

    localparam int LAT       = 2;    // first capturing edge to state reaction: sync pair + edge detect
    localparam int RESET_MIN = 480;
    localparam int PRES_WAIT = 30;
    localparam int PRES_LEN  = 120;
    localparam int SAMPLE    = 30;
    localparam int SLOT      = 70;
    localparam int MAXC      = 8192;

    logic       clk, rst_n, r_master;
    logic       I_ONE_WIRE, O_ONE_WIRE, reset_seen, rx_valid, tx_load, tx_ready, tx_done;
    logic [7:0] rx_data, tx_data;

    assign I_ONE_WIRE = r_master & O_ONE_WIRE;

    ow_slave #(.CLKS_PER_US(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I_ONE_WIRE (I_ONE_WIRE),
        .O_ONE_WIRE (O_ONE_WIRE),
        .reset_seen (reset_seen),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events per cycle, filled by the stimulus from the bus protocol rules.
    bit         exp_low [MAXC];
    bit         exp_rst [MAXC];
    bit         exp_rxv [MAXC];
    logic [7:0] exp_rxd [MAXC];
    bit         exp_txd [MAXC];
    bit         exp_ld  [MAXC];

    int n_chk = 0, n_fail = 0;
    int n_rs = 0, n_rxv = 0, n_txd = 0, n_olow = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    logic [7:0] m_rx   = 8'h00;
    bit         m_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cyc < MAXC) begin
                if (!rst_n) begin
                    m_rx   = 8'h00;
                    m_busy = 1'b0;
                end else begin
                    if (exp_ld[cyc])  m_busy = 1'b1;
                    if (exp_txd[cyc]) m_busy = 1'b0;
                    if (exp_rxv[cyc]) m_rx = exp_rxd[cyc];
                end
                chk("o_wire",     O_ONE_WIRE, exp_low[cyc] ? 0 : 1);
                chk("reset_seen", reset_seen, exp_rst[cyc]);
                chk("rx_valid",   rx_valid,   exp_rxv[cyc]);
                chk("rx_data",    rx_data,    m_rx);
                chk("tx_done",    tx_done,    exp_txd[cyc]);
                chk("tx_ready",   tx_ready,   m_busy ? 0 : 1);
                if (!O_ONE_WIRE) n_olow++;
                if (reset_seen)  n_rs++;
                if (rx_valid)    n_rxv++;
                if (tx_done)     n_txd++;
            end
        end
    end

    // Holds the master low for n_low cycles; a long enough low earns a reset pulse and a presence window.
    task automatic bus_reset(input int n_low, output int rel);
        @(negedge clk);
        r_master = 1'b0;
        repeat (n_low) @(negedge clk);
        r_master = 1'b1;
        rel = cyc + 1;
        if (n_low >= RESET_MIN) begin
            exp_rst[rel + LAT] = 1'b1;
            for (int k = 0; k < PRES_LEN; k++) exp_low[rel + LAT + PRES_WAIT + k] = 1'b1;
        end
    endtask

    task automatic write_bits(input logic [7:0] b, input int nbits);
        int p, lo;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            r_master = 1'b0;
            p  = cyc + 1;
            lo = b[i] ? 6 : 60;
            if (nbits == 8 && i == 7) begin
                exp_rxv[p + LAT + SAMPLE] = 1'b1;
                exp_rxd[p + LAT + SAMPLE] = b;
            end
            repeat (lo) @(negedge clk);
            r_master = 1'b1;
            repeat (SLOT - lo - 1) @(negedge clk);
        end
    endtask

    task automatic read_byte(input logic [7:0] b);
        int p;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r_master = 1'b0;
            p = cyc + 1;
            if (!b[i]) for (int k = 0; k < SAMPLE; k++) exp_low[p + LAT + k] = 1'b1;
            if (i == 7) exp_txd[p + LAT + SAMPLE] = 1'b1;
            repeat (2) @(negedge clk);
            r_master = 1'b1;
            if (i == 3) begin
                tx_data = 8'hFF;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                repeat (SLOT - 4) @(negedge clk);
            end else begin
                repeat (SLOT - 3) @(negedge clk);
            end
        end
    endtask

    initial begin
        int rel, olow0;
        r_master = 1'b1;
        rst_n    = 1'b0;
        tx_load  = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_o_wire",   O_ONE_WIRE, 1);
        chk("rst_tx_ready", tx_ready,   1);
        chk("rst_rx_data",  rx_data,    8'h00);
        chk("rst_rx_valid", rx_valid,   0);
        rst_n = 1'b1;

        // tx_load outside SLOT_WAIT must be ignored
        @(negedge clk);
        tx_data = 8'h55;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_load_ignored", tx_ready, 1);

        // short low is not a reset
        bus_reset(200, rel);
        repeat (250) @(negedge clk);
        chk("short_low_no_reset", n_rs, 0);
        chk("short_low_no_drive", n_olow, 0);

        bus_reset(500, rel);
        repeat (PRES_WAIT + PRES_LEN + 20) @(negedge clk);
        chk("reset_pulse_count", n_rs, 1);
        chk("presence_len", n_olow, 120);

        write_bits(8'hA5, 8);
        repeat (10) @(negedge clk);
        chk("rx_a5_data", rx_data, 8'hA5);
        chk("rx_a5_count", n_rxv, 1);

        @(negedge clk);
        tx_data = 8'h3C;
        tx_load = 1'b1;
        exp_ld[cyc + 1] = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("tx_loaded_busy", tx_ready, 0);
        olow0 = n_olow;
        read_byte(8'h3C);
        repeat (10) @(negedge clk);
        chk("read_low_cycles", n_olow - olow0, 120);
        chk("tx_done_count", n_txd, 1);
        chk("tx_ready_after", tx_ready, 1);

        // reset in the middle of a byte
        write_bits(8'h07, 3);
        bus_reset(500, rel);
        repeat (PRES_WAIT + PRES_LEN + 20) @(negedge clk);
        write_bits(8'h12, 8);
        repeat (10) @(negedge clk);
        chk("rx_12_data", rx_data, 8'h12);
        chk("rx_12_count", n_rxv, 2);
        chk("reset_pulse_count2", n_rs, 2);

        // rst_n mid-presence
        bus_reset(500, rel);
        repeat (LAT + PRES_WAIT + 50) @(negedge clk);
        chk("presence_active", O_ONE_WIRE, 0);
        rst_n = 1'b0;
        for (int c = cyc; c < MAXC; c++) exp_low[c] = 1'b0;
        #1;
        chk("rst_release_same_cycle", O_ONE_WIRE, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        olow0 = n_olow;
        repeat (300) @(negedge clk);
        chk("no_presence_after_rst", n_olow - olow0, 0);
        chk("reset_pulse_count3", n_rs, 3);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ow_slave.md
OW_SLAVE -- requirements
Module: ow_slave

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 12, meaning clk cycles per microsecond.
REQ-002 SHALL have parameter RESET_MIN_US, default 480, meaning the minimum low time recognised as a bus reset.
REQ-003 SHALL have parameter PRES_WAIT_US, default 30, meaning the delay from reset release to presence start.
REQ-004 SHALL have parameter PRES_LEN_US, default 120, meaning the presence pulse length.
REQ-005 SHALL have parameter SAMPLE_US, default 30, meaning the slot sample point after the falling edge; it is also the hold time when driving a 0.
REQ-006 SHALL have port clk, input, 1 bit: system clock, the single clock domain.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port I_ONE_WIRE, input, 1 bit: bus level, asynchronous, idle high.
REQ-009 SHALL have port O_ONE_WIRE, output, 1 bit: bus drive; 0 pulls the bus low, 1 releases it.
REQ-010 SHALL have port reset_seen, output, 1 bit: one-cycle pulse when a bus reset is recognised.
REQ-011 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-013 SHALL have port tx_data, input, 8 bits: byte to return to the master in read slots.
REQ-014 SHALL have port tx_load, input, 1 bit: loads tx_data when tx_ready=1.
REQ-015 SHALL have port tx_ready, output, 1 bit: high when no transmit byte is pending.
REQ-016 SHALL have port tx_done, output, 1 bit: one-cycle pulse after the 8th transmitted bit slot.

Function
REQ-017 SHALL pass I_ONE_WIRE through a 2-flop synchroniser; all timing below is relative to the synchronised line (2-cycle latency).
REQ-018 SHALL derive a 1 us tick from clk using CLKS_PER_US; all durations SHALL be counted in ticks, restarted on each line edge.
REQ-019 SHALL implement the states IDLE, LOW_CNT, PRES_WAIT, PRESENCE, SLOT_WAIT, SLOT, SLOT_END.
REQ-020 SHALL, on a falling edge in IDLE or SLOT_WAIT, enter LOW_CNT (IDLE) or SLOT (SLOT_WAIT).
REQ-021 SHALL, in LOW_CNT, return to IDLE on a rising edge after less than RESET_MIN_US low.
REQ-022 SHALL, in LOW_CNT, on a rising edge after RESET_MIN_US or more low, pulse reset_seen and enter PRES_WAIT.
REQ-023 SHALL drive O_ONE_WIRE=0 for exactly PRES_LEN_US in PRESENCE, then release and go to SLOT_WAIT.
REQ-024 SHALL treat the low time in any state as a bus reset once it reaches RESET_MIN_US: abort the current byte, clear the bit counter, drop any pending tx byte (tx_ready=1), and wait for release as in REQ-022.
REQ-025 SHALL, in a write slot (no tx byte pending), sample the line at SAMPLE_US after the falling edge and shift it into rx_data LSB-first; 8 bits SHALL update rx_data and pulse rx_valid.
REQ-026 SHALL, in a read slot (tx byte pending), shift out tx_data LSB-first: bit 0 drives O_ONE_WIRE=0 from the edge detect until SAMPLE_US, bit 1 keeps the bus released; after 8 slots, tx_done pulses and tx_ready=1.
REQ-027 SHALL accept tx_load only in SLOT_WAIT with tx_ready=1; a tx_load at any other time is ignored.
REQ-028 SHALL, in SLOT_END, wait for the line high and then return to SLOT_WAIT.
REQ-029 SHALL never drive O_ONE_WIRE low in IDLE, LOW_CNT, PRES_WAIT or SLOT_WAIT.

Reset
REQ-030 SHALL, while rst_n=0, immediately set O_ONE_WIRE=1, reset_seen=0, rx_valid=0, tx_done=0, tx_ready=1, rx_data=8'h00, state IDLE, and all counters to 0, even mid-presence.

Structure
REQ-031 SHALL take the state encoding and default timing constants from shared package ow_pkg, which the master side also uses.
REQ-032 SHALL place the microsecond prescaler in sub-module ow_us_tick.

Verification (CLKS_PER_US=1)
REQ-033 SHALL cover: I_ONE_WIRE low 500 cycles -> reset_seen pulse, O_ONE_WIRE low for 120 cycles starting 30 cycles after release.
REQ-034 SHALL cover: I_ONE_WIRE low 200 cycles -> no reset_seen, O_ONE_WIRE stays 1.
REQ-035 SHALL cover: after presence, write slots for 0xA5 (0 = 60 low, 1 = 6 low, 70-cycle slots) -> one rx_valid with rx_data=0xA5.
REQ-036 SHALL cover: tx_load with 0x3C, then 8 read slots of 2 low -> O_ONE_WIRE low 30 cycles in slots 0, 1, 6, 7 only; tx_done after slot 8.
REQ-037 SHALL cover: a 500-cycle reset after 3 write bits -> no rx_valid, presence issued, and the next byte 0x12 is received intact.
REQ-038 SHALL cover: rst_n=0 mid-PRESENCE -> O_ONE_WIRE=1 in the same cycle, and no presence after rst_n=1.
